// File: rtl/image_framer.sv
// Thresholds a raster-order grayscale pixel stream into a LENGTH x WIDTH binary frame.
// When the frame is complete, it pulses init_out and holds the image stable for the classifier.
module image_framer #(
    parameter int LENGTH      = 24,
    parameter int WIDTH       = 24,
    parameter int THRESHOLD   = 128,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic                      pix_sof,
    input  logic [7:0]                pix_data,
    output logic                      init_out,
    output logic [LENGTH*WIDTH-1:0]   image,
    output logic                      busy,
    output logic                      frame_err,
    output logic [7:0]                frame_count
);

    localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [8:0] THR = 9'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, LOAD, FIRE, HOLD} state_t;

    state_t state, state_d;

    logic [RW-1:0] row, row_d, wr_row;
    logic [CW-1:0] col, col_d, wr_col;
    logic [HW-1:0] hold_cnt;
    logic [LENGTH-1:0][WIDTH-1:0] img_q;
    logic accept;
    logic wr_en;
    logic pix_bit;
    logic last_px;

    assign pix_ready = (state == IDLE || state == LOAD) && !rst;
    assign accept    = pix_valid && pix_ready;
    assign pix_bit   = {1'b0, pix_data} >= THR;
    assign init_out  = (state == FIRE);
    assign busy      = (state != IDLE);
    assign image     = img_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        wr_en   = 1'b0;
        wr_row  = row;
        wr_col  = col;
        row_d   = row;
        col_d   = col;
        last_px = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && pix_sof) begin
                    wr_en  = 1'b1;
                    wr_row = '0;
                    wr_col = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (pix_sof) begin
                        wr_row = '0;
                        wr_col = '0;
                    end
                end
            end
            FIRE: state_d = HOLD;
            HOLD: begin
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_d = IDLE;
            end
        endcase
        // A sof beat always lands at (0,0); the cursor then advances from there.
        if (wr_en) begin
            last_px = (wr_row == RW'(LENGTH - 1)) && (wr_col == CW'(WIDTH - 1));
            if (last_px) begin
                row_d   = '0;
                col_d   = '0;
                state_d = FIRE;
            end else if (wr_col == CW'(WIDTH - 1)) begin
                row_d   = wr_row + 1'b1;
                col_d   = '0;
                state_d = LOAD;
            end else begin
                row_d   = wr_row;
                col_d   = wr_col + 1'b1;
                state_d = LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            img_q       <= '0;
            frame_err   <= 1'b0;
            frame_count <= '0;
            hold_cnt    <= '0;
        end else begin
            row       <= row_d;
            col       <= col_d;
            frame_err <= accept && pix_sof && (state == LOAD);
            if (wr_en) img_q[wr_row][wr_col] <= pix_bit;
            if (state == FIRE) frame_count <= frame_count + 8'd1;
            hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

endmodule
